// File: rtl/nexus_core_pkg.sv
// Shared core types: data widths, reset PC and fetch-path structures.
package nexus_core_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Clear the byte offset so every fetch address is a word address.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/nexus_fetch_ctrl_chk.sv
// Protocol and counter-range checks for the fetch sequencer.
module nexus_fetch_ctrl_chk
  import nexus_core_pkg::*;
#(
  parameter int BUF_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CW              = 3
) (
  input logic            clk,
  input logic            rst,
  input logic            imem_req,
  input logic            imem_gnt,
  input logic [XLEN-1:0] imem_addr,
  input logic            imem_rvalid,
  input logic            redirect,
  input logic [CW-1:0]   buf_count,
  input logic [CW-1:0]   outstanding,
  input logic [CW-1:0]   discard,
  input logic [CW-1:0]   tag_count,
  input logic [ILEN-1:0] tag_instr
);
  localparam logic [CW:0] DEPTH_LIM = (CW+1)'(BUF_DEPTH);
  localparam logic [CW:0] OUT_LIM   = (CW+1)'(MAX_OUTSTANDING);

  a_buf_bound:  assert property (@(posedge clk) disable iff (rst) {1'b0, buf_count} <= DEPTH_LIM);
  a_out_bound:  assert property (@(posedge clk) disable iff (rst) {1'b0, outstanding} <= OUT_LIM);
  a_inflight:   assert property (@(posedge clk) disable iff (rst)
                  ({1'b0, outstanding} + {1'b0, discard}) <= OUT_LIM);
  a_tag_sync:   assert property (@(posedge clk) disable iff (rst) tag_count == outstanding);
  a_tag_instr:  assert property (@(posedge clk) disable iff (rst) tag_instr == '0);
  a_rvalid_ok:  assert property (@(posedge clk) disable iff (rst)
                  imem_rvalid |-> ((outstanding != '0) || (discard != '0)));
  a_addr_align: assert property (@(posedge clk) disable iff (rst) imem_addr[1:0] == 2'b00);
  a_addr_hold:  assert property (@(posedge clk) disable iff (rst)
                  (imem_req && !imem_gnt) |=> (redirect || (imem_req && $stable(imem_addr))));

endmodule

// File: rtl/nexus_fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush; the head is read
// straight out of the storage registers.
module nexus_fetch_fifo
  import nexus_core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  fetch_entry_t       wdata,
  output fetch_entry_t       head,
  output logic [CNT_W-1:0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]    LAST = PW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  // A push into a full FIFO is only accepted together with a pop.
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != FULL) || do_pop);
  end

  // Storage, pointers and occupancy; flush empties without touching storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/nexus_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues word requests with
// credit-based flow control, buffers tagged responses in order and drops
// responses made stale by a redirect.
module nexus_fetch_ctrl
  import nexus_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int              BUF_DEPTH       = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [ILEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic            busy_o
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_LIM = (CW+1)'(BUF_DEPTH);
  localparam logic [CW-1:0] OUT_LIM   = CW'(MAX_OUTSTANDING);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   discard_next;
  logic [CW-1:0]   buf_count;
  logic [CW-1:0]   tag_count;
  logic            issue;
  logic            rsp_counted;
  logic            rsp_dropped;
  logic            buf_pop;
  fetch_entry_t    buf_head;
  fetch_entry_t    buf_wdata;
  fetch_entry_t    tag_head;
  fetch_entry_t    tag_wdata;

  // Request credit uses registered occupancy only; responses are either
  // counted against outstanding or consumed by a pending discard.
  always_comb begin
    imem_req_o   = !rst && (state == FETCH) && !redirect_i
                && (({1'b0, buf_count} + {1'b0, outstanding}) < DEPTH_LIM)
                && (outstanding < OUT_LIM);
    issue        = imem_req_o && imem_gnt_i;
    rsp_dropped  = imem_rvalid_i && (discard != '0);
    rsp_counted  = imem_rvalid_i && (discard == '0) && (outstanding != '0);
    discard_next = discard + outstanding + CW'(issue) - CW'(rsp_dropped || rsp_counted);
    buf_pop      = instr_valid_o && instr_ready_i;
    buf_wdata    = '{instr: imem_rdata_i, pc: tag_head.pc};
    tag_wdata    = '{instr: '0, pc: pc};
  end

  // Fetch PC, in-flight accounting and FETCH/DRAIN sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_i) begin
      pc          <= word_align(redirect_pc_i);
      outstanding <= '0;
      discard     <= discard_next;
      state       <= (discard_next != '0) ? DRAIN : FETCH;
    end else begin
      if (issue) begin
        pc <= pc + 32'd4;
      end
      outstanding <= outstanding + CW'(issue) - CW'(rsp_counted);
      if (rsp_dropped) begin
        discard <= discard - CW'(1);
      end
      case (state)
        FETCH:   state <= FETCH;
        DRAIN:   if ((discard == '0) || (rsp_dropped && (discard == CW'(1)))) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  nexus_fetch_fifo #(.DEPTH(BUF_DEPTH), .CNT_W(CW)) u_ibuf (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_counted),
    .pop   (buf_pop),
    .flush (redirect_i),
    .wdata (buf_wdata),
    .head  (buf_head),
    .count (buf_count)
  );

  nexus_fetch_fifo #(.DEPTH(MAX_OUTSTANDING), .CNT_W(CW)) u_tagq (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .pop   (rsp_counted),
    .flush (redirect_i),
    .wdata (tag_wdata),
    .head  (tag_head),
    .count (tag_count)
  );

  assign imem_addr_o   = pc;
  assign pc_o          = pc;
  assign instr_valid_o = (buf_count != '0);
  assign instr_o       = buf_head.instr;
  assign instr_pc_o    = buf_head.pc;
  assign busy_o        = (outstanding != '0) || (discard != '0);

  nexus_fetch_ctrl_chk #(
    .BUF_DEPTH       (BUF_DEPTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CW              (CW)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req_o),
    .imem_gnt    (imem_gnt_i),
    .imem_addr   (imem_addr_o),
    .imem_rvalid (imem_rvalid_i),
    .redirect    (redirect_i),
    .buf_count   (buf_count),
    .outstanding (outstanding),
    .discard     (discard),
    .tag_count   (tag_count),
    .tag_instr   (tag_head.instr)
  );

endmodule

// File: tb/tb_nexus_fetch_ctrl.sv
// Randomized bench for nexus_fetch_ctrl against a transaction-level model:
// an in-order memory with epoch-tagged pending requests and a queue of the
// PCs decode should see.
module tb_nexus_fetch_ctrl;

  localparam int          BUF_DEPTH = 4;
  localparam int          MAX_OUT   = 2;
  localparam logic [31:0] RST_PC    = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic [31:0] pc_o;
  logic        busy_o;

  nexus_fetch_ctrl #(.RESET_PC(RST_PC), .BUF_DEPTH(BUF_DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i),
    .pc_o          (pc_o),
    .busy_o        (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] buf_q[$];
  logic [31:0] m_pc;
  logic        post_rst;
  int          epoch;
  int          cyc;
  int          n_req;
  int          checks;
  int          errors;

  int          gnt_pct, ready_pct, redir_pct, rst_pct, lat_min, lat_max;
  logic        force_rst, force_redir;
  logic [31:0] force_tgt;

  function automatic logic [31:0] instr_of(input logic [31:0] addr);
    return {addr[15:0], ~addr[31:16]} ^ 32'h5A3C_0F96;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    logic        d_rst, d_redir, d_gnt, d_rdy, rv, exp_req, exp_gr, exp_pop;
    logic [31:0] tgt;
    int          stale, cur;
    mreq_t       e;
    stale = 0;
    cur   = 0;
    foreach (mem_q[i]) begin
      if (mem_q[i].epoch != epoch) stale++;
      else cur++;
    end
    d_rst   = force_rst || (int'($urandom_range(0, 99)) < rst_pct);
    d_redir = !d_rst && (force_redir || (int'($urandom_range(0, 99)) < redir_pct));
    d_gnt   = int'($urandom_range(0, 99)) < gnt_pct;
    d_rdy   = int'($urandom_range(0, 99)) < ready_pct;
    if (force_redir) tgt = force_tgt;
    else if ($urandom_range(0, 1) == 0) tgt = $urandom;
    else tgt = 32'hFFFF_FFF0 | ($urandom & 32'h0000_000F);
    rv = !d_rst && (mem_q.size() != 0) && (mem_q[0].due <= cyc);

    rst           = d_rst;
    redirect_i    = d_redir;
    redirect_pc_i = tgt;
    imem_gnt_i    = d_gnt;
    instr_ready_i = d_rdy;
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? instr_of(mem_q[0].addr) : $urandom;
    #1;

    exp_req = !d_rst && !d_redir && (stale == 0)
           && ((buf_q.size() + cur) < BUF_DEPTH) && (cur < MAX_OUT);
    chk("req", {31'd0, imem_req_o}, {31'd0, exp_req});
    if (exp_req) chk("addr", imem_addr_o, m_pc);
    chk("pc", pc_o, m_pc);
    chk("busy", {31'd0, busy_o}, {31'd0, mem_q.size() != 0});
    chk("valid", {31'd0, instr_valid_o}, {31'd0, buf_q.size() != 0});
    if (buf_q.size() != 0) begin
      chk("instr_pc", instr_pc_o, buf_q[0]);
      chk("instr", instr_o, instr_of(buf_q[0]));
    end
    if (post_rst) begin
      chk("rst_instr", instr_o, 32'd0);
      chk("rst_instr_pc", instr_pc_o, 32'd0);
    end

    exp_gr  = exp_req && d_gnt;
    exp_pop = (buf_q.size() != 0) && d_rdy && !d_redir;
    if (d_rst) begin
      m_pc = RST_PC;
      buf_q.delete();
      mem_q.delete();
      post_rst = 1'b1;
    end else begin
      post_rst = 1'b0;
      if (exp_pop) void'(buf_q.pop_front());
      if (rv) begin
        e = mem_q.pop_front();
        if (!d_redir && (e.epoch == epoch)) buf_q.push_back(e.addr);
      end
      if (exp_gr) begin
        mem_q.push_back('{addr: m_pc, epoch: epoch, due: cyc + int'($urandom_range(lat_min, lat_max))});
        m_pc = m_pc + 32'd4;
        n_req++;
      end
      if (d_redir) begin
        buf_q.delete();
        epoch++;
        m_pc = {tgt[31:2], 2'b00};
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    force_rst = 1'b1;
    step();
    force_rst = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    force_redir = 1'b1;
    force_tgt   = tgt;
    step();
    force_redir = 1'b0;
  endtask

  initial begin
    rst = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'd0;
    redirect_i = 1'b0; redirect_pc_i = 32'd0; instr_ready_i = 1'b0;
    gnt_pct = 100; ready_pct = 100; redir_pct = 0; rst_pct = 0; lat_min = 1; lat_max = 1;
    force_rst = 1'b0; force_redir = 1'b0; force_tgt = 32'd0;
    m_pc = RST_PC; post_rst = 1'b1; epoch = 0; cyc = 0; n_req = 0; checks = 0; errors = 0;
    repeat (2) @(posedge clk);
    #1;

    // streaming fetch straight out of reset
    run(12);

    // decode stalled: credit caps requests at buffer depth
    do_reset();
    ready_pct = 0;
    n_req = 0;
    run(20);
    chk("fill_reqs", n_req, 32'd4);
    chk("fill_pc", pc_o, 32'h10);
    ready_pct = 100;
    run(2);
    // reset mid-burst with buffered entries
    do_reset();
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_pc", pc_o, RST_PC);

    // grant withheld at 0x8
    run(2);
    gnt_pct = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_pc", pc_o, 32'h8);
    end
    gnt_pct = 100;
    step();
    chk("hold_release", pc_o, 32'hC);

    // redirect together with rvalid and pop
    run(6);
    do_redirect(32'h40);
    chk("flush_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("redir_pc", pc_o, 32'h40);
    run(6);

    // redirect with requests in flight, unaligned target
    lat_min = 2; lat_max = 2;
    run(8);
    do_redirect(32'h103);
    chk("redir_align", pc_o, 32'h100);
    run(10);

    // PC wrap
    lat_min = 1; lat_max = 1; gnt_pct = 0;
    run(6);
    do_redirect(32'hFFFF_FFFE);
    chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
    gnt_pct = 100;
    step();
    chk("wrap_next", pc_o, 32'h0);

    // random traffic
    gnt_pct = 70; ready_pct = 60; redir_pct = 4; rst_pct = 1; lat_min = 1; lat_max = 3;
    run(1500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nexus_fetch_ctrl.md
Name: nexus_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the Neural-Nexus RISC-V core.
- Owns the fetch PC and issues word requests to instruction memory over a req/gnt/rvalid bus. Responses are buffered in order, tagged with their PC.
- Presents instructions to decode through a valid/ready handshake.
- Handles control-flow redirects by flushing the buffer and discarding in-flight responses.
- Replaces the free-running PC+4 fetch in the core.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- BUF_DEPTH, 4, instruction buffer entries; power of two, range 2..8.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered requests; range 1..BUF_DEPTH.

Ports:
- clk  in  1  single core clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  32  fetch word address; always word aligned.
- imem_gnt_i  in  1  request accepted this cycle (only meaningful with imem_req_o).
- imem_rvalid_i  in  1  response valid; responses return in request order, at least 1 cycle after gnt.
- imem_rdata_i  in  32  instruction word.
- redirect_i  in  1  branch/jump/trap redirect strobe.
- redirect_pc_i  in  32  redirect target; bits [1:0] ignored (forced 0).
- instr_valid_o  out  1  buffer head valid.
- instr_o  out  32  buffer head instruction.
- instr_pc_o  out  32  PC of buffer head.
- instr_ready_i  in  1  decode accepts head this cycle.
- pc_o  out  32  current fetch PC (next address to be requested).
- busy_o  out  1  high when outstanding != 0 or discard != 0.

Behaviour:
- Reset values, any cycle rst=1 (mid-operation included):
  - imem_req_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, busy_o=0, pc_o=RESET_PC.
  - Buffer, outstanding and discard counters cleared; state=FETCH.
  - The instruction memory is reset by the same rst; no stale responses are expected after reset.
- State machine, FETCH and DRAIN:
  - FETCH: imem_req_o = (buf_count + outstanding < BUF_DEPTH) && (outstanding < MAX_OUTSTANDING) && !redirect_i. imem_addr_o = pc.
  - Credit counts only registered occupancy; a same-cycle pop grants no extra credit.
  - On req&&gnt: pc <= pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), outstanding+1. The issued PC is pushed to the tag queue.
  - Address stability: while req=1 and gnt=0, imem_addr_o holds. The request may be withdrawn only by redirect_i or rst.
  - DRAIN: entered on redirect_i when discard_next != 0. imem_req_o=0. Each rvalid decrements discard. Return to FETCH in the cycle after discard reaches 0.
- Redirect (any state):
  - pc <= {redirect_pc_i[31:2],2'b00}; buffer and tag queue flushed.
  - discard_next = outstanding + (req&&gnt this cycle) - (rvalid this cycle, if counted as outstanding).
  - A response arriving in the redirect cycle is dropped, never written to the buffer.
  - A decode pop in the redirect cycle is ignored; the flush wins.
  - A redirect during DRAIN re-targets pc and adds to discard per the same rule.
  - imem_req_o is 0 in the redirect cycle.
- Response path:
  - rvalid with discard=0 writes {rdata, tag_pc} to the buffer tail; outstanding-1.
  - rvalid with discard!=0 decrements discard only.
  - rvalid with outstanding=0 and discard=0 is a protocol error: ignored, flagged by an assertion.
- Output:
  - instr_valid_o = buf_count!=0; instr_o/instr_pc_o come from the head register, no combinational path from imem_rdata_i.
  - Pop on valid&&ready. A simultaneous push and pop at full occupancy is legal because credit prevents overflow.
- Latency: with gnt same cycle as req and rvalid 1 cycle later:
  - req rises in cycle 1 after rst falls; instr_valid_o rises in cycle 3.
  - After a redirect with nothing outstanding, the first req is the next cycle and the first instruction 2 cycles after that.
- Widths: buf_count and outstanding are $clog2(BUF_DEPTH)+1 bits; no counter may overflow or underflow (assertions required).

Decomposition:
- Shared package nexus_core_pkg holds:
  - XLEN=32, ILEN=32, default RESET_PC.
  - fetch_state_e {FETCH, DRAIN}.
  - fetch_entry_t struct {instr, pc}.
- One sub-module, nexus_fetch_fifo: synchronous FIFO of fetch_entry_t with push/pop/flush and a count output. It is used for the instruction buffer.
- The tag queue is a MAX_OUTSTANDING-deep instance of the same FIFO.

Test Plan:
- Reset, then memory with gnt=1 and rvalid 1 cycle later, decode ready=1 → addresses 0,4,8,… on consecutive cycles; instr_valid_o from cycle 3; instr_pc_o tracks 0,4,8.
- Decode ready=0 for 20 cycles → exactly BUF_DEPTH=4 requests issued, then imem_req_o=0. Releasing ready drains 4 instructions in order, and fetch resumes at 0x10.
- gnt withheld for 5 cycles at addr 0x8 → imem_addr_o stable at 0x8 with req=1; pc_o changes only after gnt.
- 2 requests outstanding (0x20, 0x24), redirect_i with redirect_pc_i=0x103 → both responses discarded, DRAIN for 2 rvalids, next request addr 0x100, first instr_pc_o=0x100.
- Redirect in the same cycle as rvalid and an instr_ready_i pop → response dropped, buffer empty next cycle, discard count correct, no lost or duplicated instruction.
- rst asserted mid-burst with 3 buffered entries → next cycle all outputs at reset values; fetch restarts at RESET_PC. pc wrap: redirect to 0xFFFF_FFFC → following request addr 0x0.
